// File: rtl/mor1kx_rf_arbiter_cappuccino.sv
// mor1kx_rf_arbiter_cappuccino
// Shares the single GPR-file write port between pipeline writeback, SPR-bus
// GPR accesses and (optionally) a post-reset clear sweep. Also issues SPR-bus
// GPR reads, forwarding a same-cycle write so the master never sees stale data.
//
// Build option: define MOR1KX_RF_CLEAR_EN to add the CLEAR state that zeroes
// every RF word after reset while holding the pipeline stalled.
//
// SPR handshake: the master raises spr_bus_stb_i with address/we/data and
// holds all of them stable until spr_gpr_ack_o is seen for exactly one cycle;
// it drops the strobe on the cycle after ack. Read data is meaningful only
// while ack is high. Non-GPR addresses are never acknowledged here.
module mor1kx_rf_arbiter_cappuccino #(
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_WORDS          = 32,
  parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int STALL_THRESH             = 8,
  localparam int RF_ADDR_WIDTH = OPTION_RF_ADDR_WIDTH + OPTION_RF_NUM_SHADOW_GPR,
  localparam int RF_WORDS      = OPTION_RF_WORDS * (OPTION_RF_NUM_SHADOW_GPR + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_wb_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  output logic                            spr_rd_en_o,
  output logic [RF_ADDR_WIDTH-1:0]        spr_rd_adr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_ram_dat_i,
  output logic                            rf_wren_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_stall_o,
  output logic                            rf_ready_o
);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic [3:0]                        r_wait_cnt;
  logic                              r_rd;
  logic                              r_fwd_hit;
  logic [OPTION_OPERAND_WIDTH-1:0]   r_fwd_dat;

  logic                              w_gpr_stb;
  logic [RF_ADDR_WIDTH-1:0]          w_spr_idx;
  logic                              w_thresh;
  logic                              w_wren;
  logic [RF_ADDR_WIDTH-1:0]          w_wradr;
  logic [OPTION_OPERAND_WIDTH-1:0]   w_wrdat;
  logic                              w_rd_en;
  logic                              w_ack;
  logic                              w_stall;
  logic                              w_unused_addr;

  assign w_gpr_stb     = spr_bus_stb_i & (spr_bus_addr_i[15:9] == 7'h2);
  assign w_spr_idx     = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  assign w_thresh      = (r_wait_cnt == 4'(STALL_THRESH));
  assign w_unused_addr = ^spr_bus_addr_i[8:RF_ADDR_WIDTH];

`ifdef MOR1KX_RF_CLEAR_EN
  logic [RF_ADDR_WIDTH-1:0] r_clr_cnt;
  logic                     w_clr_last;

  assign w_clr_last = (r_clr_cnt == RF_ADDR_WIDTH'(RF_WORDS - 1));

  // Sweep address advances only on cycles the clear actually owned the port.
  always_ff @(posedge clk) begin
    if (rst)
      r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR && !wb_rf_wb_i)
      r_clr_cnt <= r_clr_cnt + RF_ADDR_WIDTH'(1);
  end
`endif

  // Next state and write-port mux: writeback always wins, then clear, then SPR.
  always_comb begin
    w_next  = r_state;
    w_wren  = wb_rf_wb_i;
    w_wradr = wb_rfd_adr_i;
    w_wrdat = result_i;
    w_rd_en = 1'b0;
    w_ack   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
`ifdef MOR1KX_RF_CLEAR_EN
      ST_CLEAR: begin
        w_stall = 1'b1;
        if (!wb_rf_wb_i) begin
          w_wren  = 1'b1;
          w_wradr = r_clr_cnt;
          w_wrdat = '0;
          if (w_clr_last) w_next = ST_IDLE;
        end
      end
`endif
      ST_IDLE: begin
        if (w_gpr_stb) begin
          if (spr_bus_we_i) begin
            if (!wb_rf_wb_i) begin
              w_wren  = 1'b1;
              w_wradr = w_spr_idx;
              w_wrdat = spr_bus_dat_i;
              w_next  = ST_ACK;
            end else begin
              w_next = ST_WR_WAIT;
            end
          end else begin
            w_rd_en = 1'b1;
            w_next  = ST_ACK;
          end
        end
      end
      ST_WR_WAIT: begin
        w_stall = w_thresh;
        if (!wb_rf_wb_i) begin
          w_wren  = 1'b1;
          w_wradr = w_spr_idx;
          w_wrdat = spr_bus_dat_i;
          w_next  = ST_ACK;
        end
      end
      ST_ACK: begin
        w_ack  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Nothing may reach the RAMs or the SPR master while reset is held.
    if (rst) begin
      w_wren  = 1'b0;
      w_rd_en = 1'b0;
      w_ack   = 1'b0;
    end
  end

  // State, starvation counter and read-forwarding capture.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MOR1KX_RF_CLEAR_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_IDLE;
`endif
      r_wait_cnt <= '0;
      r_rd       <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_dat  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE)
        r_wait_cnt <= '0;
      else if (r_state == ST_WR_WAIT && wb_rf_wb_i && !w_thresh)
        r_wait_cnt <= r_wait_cnt + 4'd1;
      if (r_state == ST_IDLE && w_gpr_stb) begin
        r_rd      <= !spr_bus_we_i;
        // RAM copy returns pre-write contents; take the in-flight write instead.
        r_fwd_hit <= !spr_bus_we_i && w_wren && (w_wradr == w_spr_idx);
        r_fwd_dat <= w_wrdat;
      end
    end
  end

  assign rf_wren_o     = w_wren;
  assign rf_wradr_o    = w_wradr;
  assign rf_wrdat_o    = w_wrdat;
  assign spr_rd_en_o   = w_rd_en;
  assign spr_rd_adr_o  = w_spr_idx;
  assign spr_gpr_ack_o = w_ack;
  assign spr_gpr_dat_o = (w_ack && r_rd) ? (r_fwd_hit ? r_fwd_dat : spr_ram_dat_i) : '0;
  assign rf_stall_o    = w_stall;
  assign rf_ready_o    = (r_state != ST_CLEAR);

endmodule

// File: tb/tb_mor1kx_rf_arbiter_cappuccino.sv
// Testbench for mor1kx_rf_arbiter_cappuccino: directed SPR/writeback vectors,
// expected write-port and ack events queued by the driver, checked by a monitor.
module tb_mor1kx_rf_arbiter_cappuccino;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int RW = 32;
  localparam int TH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          wb_rf_wb_i = 1'b0;
  logic [AW-1:0] wb_rfd_adr_i = '0;
  logic [W-1:0]  result_i = '0;
  logic [15:0]   spr_bus_addr_i = '0;
  logic          spr_bus_stb_i = 1'b0;
  logic          spr_bus_we_i = 1'b0;
  logic [W-1:0]  spr_bus_dat_i = '0;
  logic          spr_gpr_ack_o;
  logic [W-1:0]  spr_gpr_dat_o;
  logic          spr_rd_en_o;
  logic [AW-1:0] spr_rd_adr_o;
  logic [W-1:0]  spr_ram_dat_i;
  logic          rf_wren_o;
  logic [AW-1:0] rf_wradr_o;
  logic [W-1:0]  rf_wrdat_o;
  logic          rf_stall_o;
  logic          rf_ready_o;

  mor1kx_rf_arbiter_cappuccino #(
    .OPTION_RF_ADDR_WIDTH(AW), .OPTION_RF_WORDS(RW), .OPTION_RF_NUM_SHADOW_GPR(0),
    .OPTION_OPERAND_WIDTH(W), .STALL_THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_rf_wb_i(wb_rf_wb_i), .wb_rfd_adr_i(wb_rfd_adr_i), .result_i(result_i),
    .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i),
    .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o), .spr_gpr_dat_o(spr_gpr_dat_o),
    .spr_rd_en_o(spr_rd_en_o), .spr_rd_adr_o(spr_rd_adr_o),
    .spr_ram_dat_i(spr_ram_dat_i),
    .rf_wren_o(rf_wren_o), .rf_wradr_o(rf_wradr_o), .rf_wrdat_o(rf_wrdat_o),
    .rf_stall_o(rf_stall_o), .rf_ready_o(rf_ready_o)
  );

  // SPR-side RF RAM copy: synchronous read returning pre-write contents.
  logic [W-1:0] ram [0:RW-1];
  always @(posedge clk) begin
    if (rf_wren_o) ram[rf_wradr_o] <= rf_wrdat_o;
    if (spr_rd_en_o) spr_ram_dat_i <= ram[spr_rd_adr_o];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [68:0] exp_wr_q[$];   // {cycle, addr, data}
  logic [64:0] exp_ack_q[$];  // {cycle, check_data, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cyc %0d got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [W-1:0] d);
    exp_wr_q.push_back({32'(c), a, d});
  endtask

  task automatic push_ack(input int c, input logic chk, input logic [W-1:0] d);
    exp_ack_q.push_back({32'(c), chk, d});
  endtask

  // Monitor: every write-port use and every ack must match the queue head.
  always @(negedge clk) begin
    logic [68:0] ew;
    logic [64:0] ea;
    if (rf_wren_o) begin
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: cyc %0d got adr %0d dat %h, required no write",
                 cyc, rf_wradr_o, rf_wrdat_o);
      end else begin
        ew = exp_wr_q.pop_front();
        if (ew[68:37] !== cyc || ew[36:32] !== rf_wradr_o || ew[31:0] !== rf_wrdat_o) begin
          n_err++;
          $display("FAIL wr_port: got cyc %0d adr %0d dat %h, required cyc %0d adr %0d dat %h",
                   cyc, rf_wradr_o, rf_wrdat_o, ew[68:37], ew[36:32], ew[31:0]);
        end
      end
    end
    if (spr_gpr_ack_o) begin
      n_cmp++;
      if (exp_ack_q.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected: cyc %0d got ack dat %h, required no ack", cyc, spr_gpr_dat_o);
      end else begin
        ea = exp_ack_q.pop_front();
        if (ea[64:33] !== cyc || (ea[32] && ea[31:0] !== spr_gpr_dat_o)) begin
          n_err++;
          $display("FAIL ack: got cyc %0d dat %h, required cyc %0d dat %h",
                   cyc, spr_gpr_dat_o, ea[64:33], ea[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_wren", 32'(rf_wren_o), 32'd0);
    check("rst_ack", 32'(spr_gpr_ack_o), 32'd0);
    check("rst_rd_en", 32'(spr_rd_en_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
`ifdef MOR1KX_RF_CLEAR_EN
    for (int i = 0; i < RW; i++) push_wr(cyc + i, AW'(i), '0);
    check("clr_stall", 32'(rf_stall_o), 32'd1);
    check("clr_ready", 32'(rf_ready_o), 32'd0);
    repeat (RW - 1) tick();
    check("clr_last_ready", 32'(rf_ready_o), 32'd0);
    tick();
`endif
    check("idle_stall", 32'(rf_stall_o), 32'd0);
    check("idle_ready", 32'(rf_ready_o), 32'd1);
  endtask

  task automatic spr_start(input logic [15:0] a, input logic we, input logic [W-1:0] d);
    spr_bus_addr_i = a;
    spr_bus_we_i   = we;
    spr_bus_dat_i  = d;
    spr_bus_stb_i  = 1'b1;
    #1;
  endtask

  // Wait (bounded) for ack, then release the strobe on the following cycle.
  task automatic spr_finish();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (spr_gpr_ack_o) got = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL ack_timeout: got no ack in 40 cycles, required ack");
    end
    tick();
    spr_bus_stb_i = 1'b0;
    spr_bus_we_i  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int n_ack;
    int n_wr;
    do_reset();

    // Unblocked SPR write, then read back through the RAM copy.
    push_wr(cyc, 5'd5, 32'hDEADBEEF);
    push_ack(cyc + 1, 1'b0, '0);
    spr_start(16'h0405, 1'b1, 32'hDEADBEEF);
    spr_finish();
    push_ack(cyc + 1, 1'b1, 32'hDEADBEEF);
    spr_start(16'h0405, 1'b0, '0);
    check("rd_en", 32'(spr_rd_en_o), 32'd1);
    check("rd_adr", 32'(spr_rd_adr_o), 32'd5);
    spr_finish();

    // Starved write: wb high N..N+6, stall N+5..N+7, grant N+7, ack N+8.
    n = cyc;
    push_ack(n + 8, 1'b0, '0);
    spr_start(16'h0401, 1'b1, 32'h11111111);
    for (int k = 0; k <= 8; k++) begin
      if (k < 7) begin
        wb_rf_wb_i   = 1'b1;
        wb_rfd_adr_i = 5'd7;
        result_i     = 32'hA000_0000 + 32'(k);
        push_wr(n + k, 5'd7, 32'hA000_0000 + 32'(k));
      end else begin
        wb_rf_wb_i = 1'b0;
      end
      if (k == 7) push_wr(n + 7, 5'd1, 32'h11111111);
      #1;
      check($sformatf("stall_k%0d", k), 32'(rf_stall_o), 32'(k >= 5 && k <= 7));
      tick();
    end
    spr_bus_stb_i = 1'b0;
    spr_bus_we_i  = 1'b0;
    tick();

    // Forwarding: read r3 in the same cycle writeback updates r3.
    push_wr(cyc, 5'd3, 32'h0BADF00D);
    push_ack(cyc + 1, 1'b0, '0);
    spr_start(16'h0403, 1'b1, 32'h0BADF00D);
    spr_finish();
    n = cyc;
    wb_rf_wb_i   = 1'b1;
    wb_rfd_adr_i = 5'd3;
    result_i     = 32'h12345678;
    push_wr(n, 5'd3, 32'h12345678);
    push_ack(n + 1, 1'b1, 32'h12345678);
    spr_start(16'h0403, 1'b0, '0);
    tick();
    wb_rf_wb_i = 1'b0;
    spr_finish();
    // Same-cycle write to a different register must not be forwarded.
    n = cyc;
    wb_rf_wb_i   = 1'b1;
    wb_rfd_adr_i = 5'd9;
    result_i     = 32'h99999999;
    push_wr(n, 5'd9, 32'h99999999);
    push_ack(n + 1, 1'b1, 32'hDEADBEEF);
    spr_start(16'h0405, 1'b0, '0);
    tick();
    wb_rf_wb_i = 1'b0;
    spr_finish();
    // r3 now read from the RAM copy.
    push_ack(cyc + 1, 1'b1, 32'h12345678);
    spr_start(16'h0403, 1'b0, '0);
    spr_finish();

    // Non-GPR SPR address: never acked, never writes.
    spr_start(16'h0801, 1'b1, 32'hFFFF0000);
    n_ack = 0;
    n_wr  = 0;
    for (int i = 0; i < 20; i++) begin
      n_ack += int'(spr_gpr_ack_o);
      n_wr  += int'(rf_wren_o);
      tick();
    end
    spr_bus_stb_i = 1'b0;
    spr_bus_we_i  = 1'b0;
    check("nongpr_acks", 32'(n_ack), 32'd0);
    check("nongpr_writes", 32'(n_wr), 32'd0);
    tick();

    // Reset while in WR_WAIT: pending write dropped, then retried.
    n = cyc;
    wb_rf_wb_i   = 1'b1;
    wb_rfd_adr_i = 5'd7;
    result_i     = 32'h77770000;
    push_wr(n, 5'd7, 32'h77770000);
    push_wr(n + 1, 5'd7, 32'h77770000);
    spr_start(16'h0402, 1'b1, 32'h55555555);
    tick();
    tick();
    spr_bus_stb_i = 1'b0;
    spr_bus_we_i  = 1'b0;
    wb_rf_wb_i    = 1'b0;
    do_reset();
    push_wr(cyc, 5'd2, 32'h55555555);
    push_ack(cyc + 1, 1'b0, '0);
    spr_start(16'h0402, 1'b1, 32'h55555555);
    spr_finish();
    push_ack(cyc + 1, 1'b1, 32'h55555555);
    spr_start(16'h0402, 1'b0, '0);
    spr_finish();

    // ---------------- final report ----------------
    repeat (3) tick();
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("ack_q_drained", 32'(exp_ack_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mor1kx_rf_arbiter_cappuccino.md
# mor1kx_rf_arbiter_cappuccino

Write-port arbiter and access sequencer for the cappuccino GPR file. It shares the single RF write port between pipeline writeback, SPR-bus GPR accesses (debug unit, shadow GPRs) and an optional post-reset clear sweep. It also issues SPR-bus GPR reads with read-after-write forwarding. It requests a pipeline stall when an SPR write is starved.

## Interface
- OPTION_RF_ADDR_WIDTH, 5, architectural GPR index width
- OPTION_RF_WORDS, 32, GPRs per context
- OPTION_RF_NUM_SHADOW_GPR, 0, shadow contexts; RF_ADDR_WIDTH = OPTION_RF_ADDR_WIDTH + OPTION_RF_NUM_SHADOW_GPR; RF_WORDS = OPTION_RF_WORDS*(OPTION_RF_NUM_SHADOW_GPR+1)
- OPTION_OPERAND_WIDTH, 32, data width
- STALL_THRESH, 8, blocked WR_WAIT cycles before stall request (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_rf_wb_i  in  1  pipeline writeback valid
- wb_rfd_adr_i  in  RF_ADDR_WIDTH  writeback address
- result_i  in  OPTION_OPERAND_WIDTH  writeback data
- spr_bus_addr_i  in  16  SPR address; GPR space when [15:9]==7'h2, RF index = [RF_ADDR_WIDTH-1:0]
- spr_bus_stb_i  in  1  SPR strobe, held until ack
- spr_bus_we_i  in  1  SPR write
- spr_bus_dat_i  in  OPTION_OPERAND_WIDTH  SPR write data
- spr_gpr_ack_o  out  1  one-cycle ack
- spr_gpr_dat_o  out  OPTION_OPERAND_WIDTH  read data, valid with ack only
- spr_rd_en_o  out  1  read enable to SPR-side RF RAM copy
- spr_rd_adr_o  out  RF_ADDR_WIDTH  read address
- spr_ram_dat_i  in  OPTION_OPERAND_WIDTH  RAM read data, one cycle after spr_rd_en_o
- rf_wren_o  out  1  RF write enable (all RAM copies)
- rf_wradr_o  out  RF_ADDR_WIDTH  write address
- rf_wrdat_o  out  OPTION_OPERAND_WIDTH  write data
- rf_stall_o  out  1  pipeline stall request
- rf_ready_o  out  1  RF initialised, pipeline may issue

## Operation
- FSM states: CLEAR, IDLE, WR_WAIT, ACK.
- Write-port priority per cycle: wb_rf_wb_i > clear sweep > SPR write.
- CLEAR: a counter walks 0..RF_WORDS-1 writing zero, one word per unblocked cycle. The counter holds when wb_rf_wb_i is high. After the last write, go to IDLE. SPR strobes are held un-acked.
- IDLE, GPR-space strobe with we=1:
  - if wb_rf_wb_i=0: write granted this cycle, go to ACK;
  - otherwise go to WR_WAIT with wait_cnt=0.
- IDLE, GPR-space strobe with we=0: assert spr_rd_en_o with spr_rd_adr_o this cycle, go to ACK.
- Forwarding: if rf_wren_o is high in the read-issue cycle and rf_wradr_o == spr_rd_adr_o, capture rf_wrdat_o and present it in ACK instead of spr_ram_dat_i.
- WR_WAIT: grant on the first cycle with wb_rf_wb_i=0, then go to ACK. Otherwise wait_cnt increments, saturating at STALL_THRESH.
- ACK: spr_gpr_ack_o=1 for one cycle, then IDLE. The master drops stb the cycle after ack.
- Non-GPR SPR addresses are ignored and never acked.
- rf_stall_o = (state==CLEAR) | (state==WR_WAIT & wait_cnt==STALL_THRESH). The pipeline guarantees wb_rf_wb_i falls within 2 cycles of stall.
- rf_ready_o = state != CLEAR.
- rst mid-operation: return to reset state. A pending SPR access is dropped un-acked and the master retries.

## Timing
- Reset values: spr_gpr_ack_o=0, spr_rd_en_o=0, rf_wren_o=0 (forced while rst high), wait_cnt=0.
- Reset values with clear compiled in: state=CLEAR, rf_stall_o=1, rf_ready_o=0.
- Reset values with clear compiled out: state=IDLE, rf_stall_o=0, rf_ready_o=1.
- rf_wren_o, rf_wradr_o and rf_wrdat_o are combinational from state and inputs; zero-latency pass-through of writeback.
- Write: stb at N, unblocked → rf_wren_o at N, ack at N+1.
- Blocked write: wb high from N to N+k-1 → grant at N+k, ack at N+k+1.
- Starvation: blocked at N, WR_WAIT from N+1 → rf_stall_o from N+1+STALL_THRESH until the grant cycle inclusive.
- Read: spr_rd_en_o at N, ack and data at N+1.
- Clear sweep, unblocked: RF_WORDS cycles; rf_ready_o rises at cycle RF_WORDS after rst release.

## Configuration
- MOR1KX_RF_CLEAR_EN defined: CLEAR state and sweep counter are built; the RF is zeroed after every reset with stall held.
- Undefined: no CLEAR state; reset enters IDLE; RF contents are undefined after reset; rf_stall_o is driven only by starvation.

## Test plan
- Reset with MOR1KX_RF_CLEAR_EN, 32 words, no wb → rf_wren_o with data 0 at addresses 0..31 on cycles 0..31; rf_ready_o=1 and rf_stall_o=0 at cycle 32.
- IDLE, SPR write addr 0x0405 data 0xDEADBEEF, wb idle → rf_wradr_o=5 that cycle, ack next cycle; a later read of 0x0405 returns 0xDEADBEEF.
- STALL_THRESH=4, SPR write while wb held high from N → rf_stall_o at N+5; wb dropped at N+7 → grant N+7, ack N+8.
- SPR read addr 0x0403 issued the same cycle wb writes r3=0x12345678 → ack data 0x12345678, not the stale RAM value.
- SPR strobe at addr 0x0801 → no ack and no rf_wren_o for 20 cycles.
- rst asserted in WR_WAIT → no ack; clear sweep restarts from address 0.
